// File: rtl/qam_pkg.sv
// qam_pkg: shared constants, carrier tables and symbol-sign helper for the QPSK modulator
package qam_pkg;
    localparam int SAMPLE_W           = 8;
    localparam int SAMPLES_PER_PERIOD = 16;
    localparam int AMPL               = 89;

    // round(AMPL * cos/sin(2*pi*k/16)), k = 0..15
    localparam logic signed [7:0] COS_LUT [SAMPLES_PER_PERIOD] = '{
        8'sd89, 8'sd82, 8'sd63, 8'sd34, 8'sd0, -8'sd34, -8'sd63, -8'sd82,
        -8'sd89, -8'sd82, -8'sd63, -8'sd34, 8'sd0, 8'sd34, 8'sd63, 8'sd82
    };
    localparam logic signed [7:0] SIN_LUT [SAMPLES_PER_PERIOD] = '{
        8'sd0, 8'sd34, 8'sd63, 8'sd82, 8'sd89, 8'sd82, 8'sd63, 8'sd34,
        8'sd0, -8'sd34, -8'sd63, -8'sd82, -8'sd89, -8'sd82, -8'sd63, -8'sd34
    };

    // Symbol bit 0 means +1, 1 means -1; result is widened to 9 bits so the mixer sum cannot wrap.
    function automatic logic signed [8:0] sign_apply(input logic neg, input logic signed [7:0] v);
        logic signed [8:0] w;
        w = {v[7], v};
        return neg ? -w : w;
    endfunction
endpackage

// File: rtl/carrier_lut.sv
// carrier_lut: combinational phase -> (cos, sin) carrier lookup
//   phase_i : 4-bit carrier phase index
//   cos_o   : signed 8-bit cosine sample
//   sin_o   : signed 8-bit sine sample
module carrier_lut
    import qam_pkg::*;
(
    input  logic [3:0]        phase_i,
    output logic signed [7:0] cos_o,
    output logic signed [7:0] sin_o
);
    assign cos_o = COS_LUT[phase_i];
    assign sin_o = SIN_LUT[phase_i];
endmodule

// File: rtl/qam4_serial_modulator.sv
// qam4_serial_modulator: 4-QAM baseband modulator, one 8-bit sample per 8-clock frame, shifted out LSB first
//   clk                   : clock, rising edge
//   rst                   : asynchronous active-low reset
//   data_in               : symbol, bit 1 = I sign, bit 0 = Q sign (0 -> +1, 1 -> -1)
//   data_bit_out          : serial sample bit, LSB first
//   data_out_complete_bit : high during bit 7 of every frame
module qam4_serial_modulator
    import qam_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] data_in,
    output logic       data_bit_out,
    output logic       data_out_complete_bit
);
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [3:0]        phase_q, phase_d;
    logic [7:0]        shreg_q, shreg_d;
    logic              bit_q, bit_d;
    logic              done_q, done_d;
    logic signed [7:0] cos_v, sin_v;
    logic signed [8:0] mix;
    logic              frame_start;

    carrier_lut u_lut (
        .phase_i (phase_q),
        .cos_o   (cos_v),
        .sin_o   (sin_v)
    );

    // |mix| <= 126, so dropping the 9th bit is lossless
    assign mix         = sign_apply(data_in[1], cos_v) + sign_apply(data_in[0], sin_v);
    assign frame_start = bit_cnt_q == 3'd0;

    always_comb begin
        shreg_d   = frame_start ? mix[7:0] : shreg_q;
        bit_d     = frame_start ? mix[0] : shreg_q[bit_cnt_q];
        done_d    = bit_cnt_q == 3'd7;
        bit_cnt_d = bit_cnt_q + 3'd1;
        phase_d   = done_d ? phase_q + 4'd1 : phase_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt_q <= '0;
            phase_q   <= '0;
            shreg_q   <= '0;
            bit_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            phase_q   <= phase_d;
            shreg_q   <= shreg_d;
            bit_q     <= bit_d;
            done_q    <= done_d;
        end
    end

    assign data_bit_out          = bit_q;
    assign data_out_complete_bit = done_q;
endmodule

// File: tb/tb_qam4_serial_modulator.sv
// tb_qam4_serial_modulator: randomized self-checking bench against a trig-based reference model
module tb_qam4_serial_modulator;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] data_in = 2'b00;
    logic       data_bit_out;
    logic       data_out_complete_bit;
    int         passed = 0;
    int         total = 0;
    int         phase_m = 0;

    qam4_serial_modulator dut (
        .clk                   (clk),
        .rst                   (rst),
        .data_in               (data_in),
        .data_bit_out          (data_bit_out),
        .data_out_complete_bit (data_out_complete_bit)
    );

    always #5 clk = ~clk;

    function automatic int rnd(input real x);
        return x >= 0.0 ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
    endfunction

    // sample = I*round(89 cos) + Q*round(89 sin), as an 8-bit two's complement pattern
    function automatic logic [7:0] model(input int ph, input logic [1:0] sym);
        real w;
        int c, s, v;
        w = 2.0 * 3.14159265358979 * (ph % 16) / 16.0;
        c = rnd(89.0 * $cos(w));
        s = rnd(89.0 * $sin(w));
        v = (sym[1] ? -c : c) + (sym[0] ? -s : s);
        return v[7:0];
    endfunction

    // Collects one frame starting from a negedge just before the frame's first edge;
    // optionally changes data_in after bit chg_at to confirm mid-frame changes are ignored.
    task automatic capture(input logic [1:0] sym, input int chg_at, input logic [1:0] chg_val,
                           output logic [7:0] val);
        data_in = sym;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            val[i] = data_bit_out;
            total++;
            if (data_out_complete_bit !== (i == 7))
                $display("FAIL complete_bit bit %0d: got %b want %b", i, data_out_complete_bit, i == 7);
            else
                passed++;
            if (i == chg_at) data_in = chg_val;
        end
        phase_m = (phase_m + 1) % 16;
    endtask

    task automatic check_frame(input string name, input logic [1:0] sym, input int chg_at,
                               input logic [1:0] chg_val);
        logic [7:0] got, exp;
        exp = model(phase_m, sym);
        capture(sym, chg_at, chg_val, got);
        total++;
        if (got !== exp) $display("FAIL %s: got %h want %h", name, got, exp);
        else passed++;
    endtask

    task automatic restart();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        phase_m = 0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            data_in = 2'($urandom);
            total++;
            if (data_bit_out !== 1'b0 || data_out_complete_bit !== 1'b0)
                $display("FAIL reset_hold cycle %0d: got %b%b want 00", i, data_bit_out, data_out_complete_bit);
            else
                passed++;
        end
        data_in = 2'b00;
        rst = 1'b1;
        phase_m = 0;
    endtask

    task automatic test_first_frame();
        logic [7:0] got;
        capture(2'b00, 8, 2'b00, got);
        total++;
        if (got !== 8'h59) $display("FAIL first_frame: got %h want 59", got);
        else passed++;
    endtask

    task automatic test_period();
        for (int f = 1; f <= 16; f++) check_frame("period", 2'b00, 8, 2'b00);
        check_frame("period_wrap", 2'b00, 8, 2'b00);
    endtask

    task automatic test_phase2();
        logic [1:0] syms [3] = '{2'b11, 2'b01, 2'b10};
        logic [7:0] exps [3] = '{8'h82, 8'h00, 8'h00};
        logic [7:0] got;
        for (int k = 0; k < 3; k++) begin
            restart();
            check_frame("phase2_lead", 2'b00, 8, 2'b00);
            check_frame("phase2_lead", 2'b00, 8, 2'b00);
            capture(syms[k], 8, 2'b00, got);
            total++;
            if (got !== exps[k]) $display("FAIL phase2 sym %b: got %h want %h", syms[k], got, exps[k]);
            else passed++;
        end
    endtask

    task automatic test_midframe_change();
        logic [7:0] got;
        restart();
        capture(2'b00, 3, 2'b11, got);
        total++;
        if (got !== 8'h59) $display("FAIL midframe_f0: got %h want 59", got);
        else passed++;
        capture(2'b11, 8, 2'b00, got);
        total++;
        if (got !== 8'h8c) $display("FAIL midframe_f1: got %h want 8c", got);
        else passed++;
    endtask

    task automatic test_random();
        logic [1:0] sym;
        restart();
        for (int f = 0; f < 40; f++) begin
            sym = 2'($urandom);
            check_frame("random", sym, $urandom_range(0, 6), 2'($urandom));
        end
    endtask

    task automatic test_reset_midframe();
        restart();
        for (int f = 0; f < 3; f++) check_frame("prereset", 2'($urandom), 8, 2'b00);
        data_in = 2'b11;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (data_bit_out !== 1'b0 || data_out_complete_bit !== 1'b0)
            $display("FAIL reset_async: got %b%b want 00", data_bit_out, data_out_complete_bit);
        else
            passed++;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        phase_m = 0;
        check_frame("after_reset", 2'b00, 8, 2'b00);
        check_frame("after_reset_f1", 2'b00, 8, 2'b00);
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_period();
        test_phase2();
        test_midframe_change();
        test_random();
        test_reset_midframe();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/qam4_serial_modulator.md
# qam4_serial_modulator

4-QAM (QPSK) baseband modulator with a serial sample output. Each 2-bit symbol on `data_in` selects the signs of the in-phase and quadrature carrier components. The block computes one 8-bit signed carrier sample per 8-clock frame from an internal cosine/sine table. It shifts that sample out one bit per clock and flags the last bit of each frame. This is the top-level of the modulation path, and it feeds a serial link or DAC interface.

## Interface
- `SAMPLES_PER_PERIOD`, 16: carrier table length; the phase index wraps at this value.
- `SAMPLE_W`, 8: sample width, equal to the frame length in clocks.
- `AMPL`, 89: carrier amplitude used to build the tables.
- `clk`  in  1: the single clock; all logic is on its rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `data_in`  in  2: QAM symbol. Bit 1 selects the I sign and bit 0 selects the Q sign; 0 means +1 and 1 means −1.
- `data_bit_out`  out  1: serial sample bit, LSB first.
- `data_out_complete_bit`  out  1: high for one cycle, during the last bit (bit 7) of each frame.

## Operation
- The tables are constants: `COS_LUT[k] = round(AMPL·cos(2πk/16))` and `SIN_LUT[k] = round(AMPL·sin(2πk/16))`, for k = 0..15, stored as 8-bit signed values.
- The sample is `s = I·COS_LUT[phase] + Q·SIN_LUT[phase]`.
  - I and Q are each ±1, taken from `data_in`.
  - Compute at 9 bits, then truncate to 8-bit two's complement.
  - With `AMPL` = 89, |s| ≤ 126, so the result never overflows.
- State:
  - 3-bit `bit_cnt`
  - 4-bit `phase`
  - 8-bit `shreg`
  - the two registered outputs
- On every clock edge:
  - If `bit_cnt` = 0: compute `s` from the current `data_in` and `phase`, load `s` into `shreg`, and set `data_bit_out` ← `s[0]`.
  - Otherwise: `data_bit_out` ← `shreg[bit_cnt]`.
  - `data_out_complete_bit` ← (`bit_cnt` = 7).
  - `bit_cnt` ← `bit_cnt` + 1, wrapping 7→0.
  - If `bit_cnt` = 7: `phase` ← `phase` + 1, wrapping 15→0.
- `data_in` is sampled only at frame start (`bit_cnt` = 0). Changes mid-frame take effect in the next frame.

## Timing
- Reset values: `data_bit_out` = 0, `data_out_complete_bit` = 0, `bit_cnt` = 0, `phase` = 0, `shreg` = 0.
- The first rising edge after `rst` deasserts starts frame 0 at phase 0.
- Latency: 1 clock from the edge that samples `data_in` to `s[0]` appearing on `data_bit_out`.
- Bit i of the sample is valid in the cycle following frame edge i, for i = 0..7.
- `data_out_complete_bit` is high in the same cycle as bit 7, so one pulse occurs every 8 clocks. There are no gaps between frames and no backpressure.
- One carrier period takes 16 frames, which is 128 clocks.
- Reset asserted mid-frame aborts the frame immediately; all state returns to reset values.

## Structure
- Package `qam_pkg` holds:
  - `SAMPLE_W`, `SAMPLES_PER_PERIOD`, `AMPL`
  - the `COS_LUT` and `SIN_LUT` constant arrays
  - the symbol-to-sign mapping function
- Sub-module `carrier_lut` is a combinational phase → (cos, sin) lookup. `qam4_serial_modulator` keeps the frame counter, phase accumulator, mixer, and serializer.

## Test plan
- Hold `rst` = 0 for 100 clocks with `data_in` toggling → both outputs stay 0 and there are no complete pulses.
- Release reset with `data_in` = 00 → frame 0 reassembles to 0x59 (89); LSB-first bits are 1,0,0,1,1,0,1,0. The complete pulse coincides with the 8th bit, and pulses then repeat every 8 clocks.
- `data_in` = 00 for 16 frames → samples are 89, 116, 126, 116, 89, …, and phase 16 equals phase 0 (89). Phase 2 gives 126 (0x7E).
- At phase 2: `data_in` = 11 → 0x82 (−126); `data_in` = 01 → 0x00; `data_in` = 10 → 0x00.
- Change `data_in` 00→11 at `bit_cnt` = 3 of frame 0 → frame 0 is still 0x59 and frame 1 is −116 (0x8C).
- Assert `rst` at `bit_cnt` = 5 of frame 3, then release → outputs go to 0 at once, and the next frame restarts at phase 0 with value 89 for `data_in` = 00.
